// File: rtl/mem_wb_nway_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_nway_pkg
//   Shared CPU definitions for the MEM/WB stage:
//   - stall-vector bit positions (STALL_MEM, STALL_WB) and vector width
//   - default datapath widths (DATA_W, REG_AW)
//   - NOP constants driven into the stage when a bubble is inserted
//   - the per-edge action of the stage register and a helper that decodes it
// ---------------------------------------------------------------------------
package mem_wb_nway_pkg;

    localparam int STALL_W    = 6;
    localparam int STALL_MEM  = 4;   // stall bit for the MEM/WB register itself
    localparam int STALL_WB   = 5;   // stall bit for the downstream WB stage

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    // A bubble is a write-nothing instruction: all enables low.
    localparam logic NOP_EN  = 1'b0;
    localparam logic NOP_BIT = 1'b0;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } stage_act_e;

    // Priority: flush > bubble > hold > load.
    // A stalled MEM with a running WB must not let WB re-execute the old
    // bundle, so it gets a bubble; if WB is stalled too, everything holds.
    function automatic stage_act_e stage_action(input logic flush,
                                                input logic stall_mem,
                                                input logic stall_wb);
        stage_act_e act;
        if (flush) begin
            act = ACT_BUBBLE;
        end else if (stall_mem && !stall_wb) begin
            act = ACT_BUBBLE;
        end else if (stall_mem) begin
            act = ACT_HOLD;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

endpackage

// File: rtl/mem_wb_lane_merge.sv
// ---------------------------------------------------------------------------
// mem_wb_lane_merge
//   Combinational front end of the MEM/WB register. Qualifies each lane by
//   its valid bit, resolves same-cycle GPR write collisions (younger lane
//   wins) and merges the HI/LO and LL-bit requests into single requests.
// Ports
//   valid_i        lane carries a real instruction (lane 0 = oldest)
//   wd_i/wreg_i/wdata_i          per-lane GPR write request
//   whilo_i/hi_i/lo_i            per-lane HI/LO write request
//   llbit_we_i/llbit_value_i     per-lane LL-bit write request
//   wd_o/wdata_o   qualified dest reg / data (0 for invalid lanes)
//   wreg_o         qualified, collision-resolved GPR write enable
//   whilo_o/hi_o/lo_o            merged HI/LO request
//   llbit_we_o/llbit_value_o     merged LL-bit request
// ---------------------------------------------------------------------------
module mem_wb_lane_merge
    import mem_wb_nway_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [LANES-1:0]        valid_i,
    input  logic [LANES*REG_AW-1:0] wd_i,
    input  logic [LANES-1:0]        wreg_i,
    input  logic [LANES*DATA_W-1:0] wdata_i,
    input  logic [LANES-1:0]        whilo_i,
    input  logic [LANES*DATA_W-1:0] hi_i,
    input  logic [LANES*DATA_W-1:0] lo_i,
    input  logic [LANES-1:0]        llbit_we_i,
    input  logic [LANES-1:0]        llbit_value_i,
    output logic [LANES*REG_AW-1:0] wd_o,
    output logic [LANES-1:0]        wreg_o,
    output logic [LANES*DATA_W-1:0] wdata_o,
    output logic                    whilo_o,
    output logic [DATA_W-1:0]       hi_o,
    output logic [DATA_W-1:0]       lo_o,
    output logic                    llbit_we_o,
    output logic                    llbit_value_o
);

    logic [REG_AW-1:0] q_wd [LANES];
    logic [LANES-1:0]  q_wreg;
    logic [LANES-1:0]  q_whilo;
    logic [LANES-1:0]  q_llwe;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic superseded;

        assign q_wd[gi]    = valid_i[gi] ? wd_i[gi*REG_AW +: REG_AW] : '0;
        assign q_wreg[gi]  = valid_i[gi] & wreg_i[gi];
        assign q_whilo[gi] = valid_i[gi] & whilo_i[gi];
        assign q_llwe[gi]  = valid_i[gi] & llbit_we_i[gi];

        assign wd_o[gi*REG_AW +: REG_AW]    = q_wd[gi];
        assign wdata_o[gi*DATA_W +: DATA_W] = valid_i[gi] ? wdata_i[gi*DATA_W +: DATA_W] : '0;

        // A younger lane writing the same register makes this write dead.
        always_comb begin
            superseded = 1'b0;
            for (int j = gi + 1; j < LANES; j++) begin
                if (q_wreg[j] && (q_wd[j] == q_wd[gi])) begin
                    superseded = 1'b1;
                end
            end
        end

        // $zero writes are left alone; the register file discards them.
        assign wreg_o[gi] = q_wreg[gi] & ~(superseded & (q_wd[gi] != '0));
    end

    assign whilo_o    = |q_whilo;
    assign llbit_we_o = |q_llwe;

    // Ascending scan: the last (youngest) requesting lane overwrites older ones.
    always_comb begin
        hi_o          = '0;
        lo_o          = '0;
        llbit_value_o = NOP_BIT;
        for (int i = 0; i < LANES; i++) begin
            if (q_whilo[i]) begin
                hi_o = hi_i[i*DATA_W +: DATA_W];
                lo_o = lo_i[i*DATA_W +: DATA_W];
            end
            if (q_llwe[i]) begin
                llbit_value_o = llbit_value_i[i];
            end
        end
    end

endmodule

// File: rtl/mem_wb_nway.sv
// ---------------------------------------------------------------------------
// mem_wb_nway
//   MEM/WB pipeline register for a LANES-wide issue core, with per-lane
//   valid, flush, collision resolution (via mem_wb_lane_merge) and a
//   retired-instruction counter. LANES=1 gives the single-issue stage.
// Ports
//   clk_i              rising-edge clock
//   rst_ni             asynchronous reset, active-low
//   stall_i[5:0]       stall vector; bit 4 = this stage, bit 5 = WB
//   flush_i            squash the incoming bundle
//   mem_*_i            per-lane requests from MEM (lane i at slice i)
//   wb_valid_o         registered lane valid
//   wb_wd_o/wb_wreg_o/wb_wdata_o     registered GPR write per lane
//   wb_whilo_o/wb_hi_o/wb_lo_o       merged HI/LO write
//   wb_llbit_we_o/wb_llbit_value_o   merged LL-bit write
//   retire_cnt_o       instructions retired since reset (wraps)
// ---------------------------------------------------------------------------
module mem_wb_nway
    import mem_wb_nway_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [STALL_W-1:0]      stall_i,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        mem_valid_i,
    input  logic [LANES*REG_AW-1:0] mem_wd_i,
    input  logic [LANES-1:0]        mem_wreg_i,
    input  logic [LANES*DATA_W-1:0] mem_wdata_i,
    input  logic [LANES-1:0]        mem_whilo_i,
    input  logic [LANES*DATA_W-1:0] mem_hi_i,
    input  logic [LANES*DATA_W-1:0] mem_lo_i,
    input  logic [LANES-1:0]        mem_llbit_we_i,
    input  logic [LANES-1:0]        mem_llbit_value_i,
    output logic [LANES-1:0]        wb_valid_o,
    output logic [LANES*REG_AW-1:0] wb_wd_o,
    output logic [LANES-1:0]        wb_wreg_o,
    output logic [LANES*DATA_W-1:0] wb_wdata_o,
    output logic                    wb_whilo_o,
    output logic [DATA_W-1:0]       wb_hi_o,
    output logic [DATA_W-1:0]       wb_lo_o,
    output logic                    wb_llbit_we_o,
    output logic                    wb_llbit_value_o,
    output logic [CNT_W-1:0]        retire_cnt_o
);

    // Only the MEM and WB stall bits matter to this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall_i[STALL_MEM-1:0];

    // ---------------- combinational merge ----------------
    logic [LANES*REG_AW-1:0] m_wd;
    logic [LANES-1:0]        m_wreg;
    logic [LANES*DATA_W-1:0] m_wdata;
    logic                    m_whilo;
    logic [DATA_W-1:0]       m_hi;
    logic [DATA_W-1:0]       m_lo;
    logic                    m_llwe;
    logic                    m_llval;

    mem_wb_lane_merge #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_merge (
        .valid_i       (mem_valid_i),
        .wd_i          (mem_wd_i),
        .wreg_i        (mem_wreg_i),
        .wdata_i       (mem_wdata_i),
        .whilo_i       (mem_whilo_i),
        .hi_i          (mem_hi_i),
        .lo_i          (mem_lo_i),
        .llbit_we_i    (mem_llbit_we_i),
        .llbit_value_i (mem_llbit_value_i),
        .wd_o          (m_wd),
        .wreg_o        (m_wreg),
        .wdata_o       (m_wdata),
        .whilo_o       (m_whilo),
        .hi_o          (m_hi),
        .lo_o          (m_lo),
        .llbit_we_o    (m_llwe),
        .llbit_value_o (m_llval)
    );

    // ---------------- stage registers ----------------
    logic [LANES-1:0]        valid_q,  valid_d;
    logic [LANES*REG_AW-1:0] wd_q,     wd_d;
    logic [LANES-1:0]        wreg_q,   wreg_d;
    logic [LANES*DATA_W-1:0] wdata_q,  wdata_d;
    logic                    whilo_q,  whilo_d;
    logic [DATA_W-1:0]       hi_q,     hi_d;
    logic [DATA_W-1:0]       lo_q,     lo_d;
    logic                    llwe_q,   llwe_d;
    logic                    llval_q,  llval_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;

    stage_act_e       act;
    logic [LANES-1:0] retire_mask;
    logic [CNT_W-1:0] retire_inc;

    // Flush already forces a bubble, so this mask only matters defensively.
    assign retire_mask = mem_valid_i & ~{LANES{flush_i}};

    always_comb begin
        act = stage_action(flush_i, stall_i[STALL_MEM], stall_i[STALL_WB]);

        retire_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            retire_inc = retire_inc + CNT_W'(retire_mask[i]);
        end

        valid_d = valid_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        llwe_d  = llwe_q;
        llval_d = llval_q;
        cnt_d   = cnt_q;

        case (act)
            ACT_LOAD: begin
                valid_d = mem_valid_i;
                wd_d    = m_wd;
                wreg_d  = m_wreg;
                wdata_d = m_wdata;
                whilo_d = m_whilo;
                hi_d    = m_hi;
                lo_d    = m_lo;
                llwe_d  = m_llwe;
                llval_d = m_llval;
                cnt_d   = cnt_q + retire_inc;   // wraps modulo 2^CNT_W
            end
            ACT_BUBBLE: begin
                valid_d = '0;
                wd_d    = '0;
                wreg_d  = {LANES{NOP_EN}};
                wdata_d = '0;
                whilo_d = NOP_EN;
                hi_d    = '0;
                lo_d    = '0;
                llwe_d  = NOP_EN;
                llval_d = NOP_BIT;
            end
            default: begin
                // ACT_HOLD: keep everything
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            wd_q    <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            llwe_q  <= 1'b0;
            llval_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            llwe_q  <= llwe_d;
            llval_q <= llval_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid_o       = valid_q;
    assign wb_wd_o          = wd_q;
    assign wb_wreg_o        = wreg_q;
    assign wb_wdata_o       = wdata_q;
    assign wb_whilo_o       = whilo_q;
    assign wb_hi_o          = hi_q;
    assign wb_lo_o          = lo_q;
    assign wb_llbit_we_o    = llwe_q;
    assign wb_llbit_value_o = llval_q;
    assign retire_cnt_o     = cnt_q;

endmodule

// File: tb/tb_mem_wb_nway.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_nway
//   Directed bench for mem_wb_nway (LANES=2, DATA_W=32, REG_AW=5, CNT_W=4).
//   The driver pushes a hand-computed expected output bundle, tagged with the
//   cycle it should appear in; a separate monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_mem_wb_nway;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    rst_n;
    logic [5:0]              stall;
    logic                    flush;
    logic [LANES-1:0]        mem_valid;
    logic [LANES*REG_AW-1:0] mem_wd;
    logic [LANES-1:0]        mem_wreg;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]        mem_whilo;
    logic [LANES*DATA_W-1:0] mem_hi;
    logic [LANES*DATA_W-1:0] mem_lo;
    logic [LANES-1:0]        mem_llwe;
    logic [LANES-1:0]        mem_llval;
    logic [LANES-1:0]        wb_valid;
    logic [LANES*REG_AW-1:0] wb_wd;
    logic [LANES-1:0]        wb_wreg;
    logic [LANES*DATA_W-1:0] wb_wdata;
    logic                    wb_whilo;
    logic [DATA_W-1:0]       wb_hi;
    logic [DATA_W-1:0]       wb_lo;
    logic                    wb_llwe;
    logic                    wb_llval;
    logic [CNT_W-1:0]        retire_cnt;

    mem_wb_nway #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .stall_i           (stall),
        .flush_i           (flush),
        .mem_valid_i       (mem_valid),
        .mem_wd_i          (mem_wd),
        .mem_wreg_i        (mem_wreg),
        .mem_wdata_i       (mem_wdata),
        .mem_whilo_i       (mem_whilo),
        .mem_hi_i          (mem_hi),
        .mem_lo_i          (mem_lo),
        .mem_llbit_we_i    (mem_llwe),
        .mem_llbit_value_i (mem_llval),
        .wb_valid_o        (wb_valid),
        .wb_wd_o           (wb_wd),
        .wb_wreg_o         (wb_wreg),
        .wb_wdata_o        (wb_wdata),
        .wb_whilo_o        (wb_whilo),
        .wb_hi_o           (wb_hi),
        .wb_lo_o           (wb_lo),
        .wb_llbit_we_o     (wb_llwe),
        .wb_llbit_value_o  (wb_llval),
        .retire_cnt_o      (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          id;
        int          due;
        logic [1:0]  valid;
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic kick   = 1'b0;

    task automatic chk(input int id, input string fld, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, fld, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, or on a kick for
    // checks that must land between two rising edges (async reset).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge kick);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk(e.id, "wb_valid",   64'(wb_valid),   64'(e.valid));
                chk(e.id, "wb_wd",      64'(wb_wd),      64'(e.wd));
                chk(e.id, "wb_wreg",    64'(wb_wreg),    64'(e.wreg));
                chk(e.id, "wb_wdata",   wb_wdata,        e.wdata);
                chk(e.id, "wb_whilo",   64'(wb_whilo),   64'(e.whilo));
                chk(e.id, "wb_hi",      64'(wb_hi),      64'(e.hi));
                chk(e.id, "wb_lo",      64'(wb_lo),      64'(e.lo));
                chk(e.id, "wb_llwe",    64'(wb_llwe),    64'(e.llwe));
                chk(e.id, "wb_llval",   64'(wb_llval),   64'(e.llval));
                chk(e.id, "retire_cnt", 64'(retire_cnt), 64'(e.cnt));
                $display("vec%0d cycle %0d compared, errors so far %0d", e.id, cyc, errors);
            end
        end
    end

    task automatic exp_push(input int id, input int due, input logic [1:0] v,
                            input logic [4:0] wd1, input logic [4:0] wd0, input logic [1:0] wreg,
                            input logic [31:0] d1, input logic [31:0] d0,
                            input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                            input logic llwe, input logic llval, input logic [3:0] cnt);
        exp_t e;
        e.id = id; e.due = due; e.valid = v; e.wd = {wd1, wd0}; e.wreg = wreg;
        e.wdata = {d1, d0}; e.whilo = whilo; e.hi = hi; e.lo = lo;
        e.llwe = llwe; e.llval = llval; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic lane(input int l, input logic v, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] d, input logic whilo, input logic [31:0] hi,
                        input logic [31:0] lo, input logic llwe, input logic llval);
        mem_valid[l]            = v;
        mem_wd[l*REG_AW +: REG_AW] = wd;
        mem_wreg[l]             = wreg;
        mem_wdata[l*DATA_W +: DATA_W] = d;
        mem_whilo[l]            = whilo;
        mem_hi[l*DATA_W +: DATA_W] = hi;
        mem_lo[l*DATA_W +: DATA_W] = lo;
        mem_llwe[l]             = llwe;
        mem_llval[l]            = llval;
    endtask

    task automatic ctl(input logic [5:0] st, input logic fl);
        stall = st;
        flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_expect_now(input int id);
        exp_push(id, cyc, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
        #1 kick = 1'b1;
        #1 kick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ctl(6'b000000, 1'b0);
        lane(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lane(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        #1;
        zero_expect_now(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // load
        lane(0, 1, 3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        lane(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ctl(6'b000000, 0);
        exp_push(1, cyc+1, 2'b01, 0, 3, 2'b01, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4'd1);
        tick();
        // hold: new inputs ignored
        lane(0, 1, 9, 1, 32'h1234, 0, 0, 0, 0, 0);
        lane(1, 1, 8, 1, 32'h5678, 0, 0, 0, 0, 0);
        ctl(6'b110000, 0);
        exp_push(2, cyc+1, 2'b01, 0, 3, 2'b01, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4'd1);
        tick();
        // bubble
        ctl(6'b010000, 0);
        exp_push(3, cyc+1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd1);
        tick();
        // GPR collision on r7: younger lane wins
        lane(0, 1, 7, 1, 32'h11, 0, 0, 0, 0, 0);
        lane(1, 1, 7, 1, 32'h22, 0, 0, 0, 0, 0);
        ctl(6'b000000, 0);
        exp_push(4, cyc+1, 2'b11, 7, 7, 2'b10, 32'h22, 32'h11, 0, 0, 0, 0, 0, 4'd3);
        tick();
        // collision on r0 is left alone
        lane(0, 1, 0, 1, 32'h11, 0, 0, 0, 0, 0);
        lane(1, 1, 0, 1, 32'h22, 0, 0, 0, 0, 0);
        exp_push(5, cyc+1, 2'b11, 0, 0, 2'b11, 32'h22, 32'h11, 0, 0, 0, 0, 0, 4'd5);
        tick();
        // HI/LO and LL-bit both lanes: lane1 wins
        lane(0, 1, 0, 0, 0, 1, 32'hA, 32'h1, 1, 0);
        lane(1, 1, 0, 0, 0, 1, 32'hB, 32'h2, 1, 1);
        exp_push(6, cyc+1, 2'b11, 0, 0, 2'b00, 0, 0, 1, 32'hB, 32'h2, 1, 1, 4'd7);
        tick();
        // only lane0 requests HI/LO and LL-bit
        lane(0, 1, 0, 0, 0, 1, 32'hA, 32'h1, 1, 1);
        lane(1, 1, 0, 0, 0, 0, 32'hB, 32'h2, 0, 0);
        exp_push(7, cyc+1, 2'b11, 0, 0, 2'b00, 0, 0, 1, 32'hA, 32'h1, 1, 1, 4'd9);
        tick();
        // invalid lane1 requests everything: all squashed
        lane(0, 1, 4, 1, 32'h44, 0, 0, 0, 0, 0);
        lane(1, 0, 5, 1, 32'h55, 1, 32'h5, 32'h5, 1, 1);
        exp_push(8, cyc+1, 2'b01, 0, 4, 2'b01, 0, 32'h44, 0, 0, 0, 0, 0, 4'd10);
        tick();
        // flush with stall=0
        lane(0, 1, 1, 1, 32'h1, 0, 0, 0, 0, 0);
        lane(1, 1, 2, 1, 32'h2, 0, 0, 0, 0, 0);
        ctl(6'b000000, 1);
        exp_push(9, cyc+1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd10);
        tick();
        ctl(6'b000000, 0);
        exp_push(10, cyc+1, 2'b11, 2, 1, 2'b11, 32'h2, 32'h1, 0, 0, 0, 0, 0, 4'd12);
        tick();
        // flush beats hold
        ctl(6'b110000, 1);
        exp_push(11, cyc+1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd12);
        tick();
        // single-lane loads up to 15
        ctl(6'b000000, 0);
        lane(0, 1, 6, 1, 32'h66, 0, 0, 0, 0, 0);
        lane(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            exp_push(12+k, cyc+1, 2'b01, 0, 6, 2'b01, 0, 32'h66, 0, 0, 0, 0, 0, 4'(13+k));
            tick();
        end
        // wrap: 15 + 2 = 1 mod 16
        lane(0, 1, 1, 1, 32'hA1, 0, 0, 0, 0, 0);
        lane(1, 1, 2, 1, 32'hB2, 0, 0, 0, 0, 0);
        exp_push(15, cyc+1, 2'b11, 2, 1, 2'b11, 32'hB2, 32'hA1, 0, 0, 0, 0, 0, 4'd1);
        tick();

        // async reset mid-cycle with non-zero outputs, under a hold stall
        ctl(6'b110000, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        zero_expect_now(16);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // first load after release
        lane(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lane(1, 1, 2, 1, 32'hABC, 0, 0, 0, 0, 0);
        ctl(6'b000000, 0);
        exp_push(17, cyc+1, 2'b10, 2, 0, 2'b10, 32'hABC, 0, 0, 0, 0, 0, 0, 4'd1);
        tick();

        // drain with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
